// File: rtl/lb_event_counters_if.sv
// Local Bus write/read channel bundle shared by a bus master and a register block.
// The master drives the address/data/strobes; the slave returns acknowledges and read data.
interface lb_event_counters_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int STRB_W = DATA_W / 8
);
  logic [ADDR_W-1:0] lb_waddr;
  logic [DATA_W-1:0] lb_wdata;
  logic              lb_wen;
  logic [STRB_W-1:0] lb_wstrb;
  logic              lb_wready;
  logic [ADDR_W-1:0] lb_raddr;
  logic              lb_ren;
  logic [DATA_W-1:0] lb_rdata;
  logic              lb_rvalid;

  modport master (
    output lb_waddr, lb_wdata, lb_wen, lb_wstrb, lb_raddr, lb_ren,
    input  lb_wready, lb_rdata, lb_rvalid
  );

  modport slave (
    input  lb_waddr, lb_wdata, lb_wen, lb_wstrb, lb_raddr, lb_ren,
    output lb_wready, lb_rdata, lb_rvalid
  );
endinterface

// File: rtl/lb_event_counters.sv
// Bank of N_CH event counters plus a CTRL register on the Local Bus, with wrap or
// saturate mode, optional read-to-clear, sticky W1C overflow flags and a maskable irq.
module lb_event_counters #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int STRB_W = DATA_W / 8,
  parameter int N_CH   = 4,
  parameter int CNT_W  = 12,
  parameter int SAT    = 0,
  parameter int RC     = 0,
  parameter int BASE   = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  lb_event_counters_if.slave     lb,
  input  logic [N_CH-1:0]        cnt_inc,
  input  logic [N_CH-1:0]        cnt_upd,
  input  logic [N_CH*CNT_W-1:0]  cnt_new,
  output logic [N_CH*CNT_W-1:0]  cnt_val,
  output logic [N_CH-1:0]        cnt_ovf,
  output logic                   irq
);

  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [ADDR_W-1:0] CTRL_ADDR = ADDR_W'(BASE + N_CH * STRB_W);

  function automatic logic [ADDR_W-1:0] ch_addr(input int idx);
    return ADDR_W'(BASE + idx * STRB_W);
  endfunction

  logic [N_CH-1:0][CNT_W-1:0] r_cnt;
  logic [N_CH-1:0]            r_ovf;
  logic [N_CH-1:0]            r_inc_en;
  logic [N_CH-1:0]            r_irq_en;
  logic                       r_wready;
  logic                       r_rvalid;
  logic [DATA_W-1:0]          r_rdata;
  logic                       r_irq;

  logic [N_CH-1:0][CNT_W-1:0] w_cnt_nxt;
  logic [N_CH-1:0]            w_ovf_nxt;
  logic [N_CH-1:0]            w_inc_en_nxt;
  logic [N_CH-1:0]            w_irq_en_nxt;
  logic [N_CH-1:0]            w_wr_ch;
  logic [N_CH-1:0]            w_rd_ch;
  logic [N_CH-1:0]            w_inc_eff;
  logic [N_CH-1:0]            w_ovf_evt;
  logic                       w_wr_ctrl;
  logic                       w_rd_ctrl;
  logic [DATA_W-1:0]          w_bit_en;
  logic [DATA_W-1:0]          w_rdata;

  for (genvar b = 0; b < DATA_W; b++) begin : g_bit_en
    assign w_bit_en[b] = lb.lb_wstrb[b/8];
  end

  assign w_inc_eff = cnt_inc & r_inc_en;
  assign w_wr_ctrl = lb.lb_wen && (lb.lb_waddr == CTRL_ADDR);
  assign w_rd_ctrl = lb.lb_ren && (lb.lb_raddr == CTRL_ADDR);

  // Per-channel address decode for writes and reads.
  always_comb begin
    w_wr_ch = '0;
    w_rd_ch = '0;
    for (int i = 0; i < N_CH; i++) begin
      w_wr_ch[i] = lb.lb_wen && (lb.lb_waddr == ch_addr(i));
      w_rd_ch[i] = lb.lb_ren && (lb.lb_raddr == ch_addr(i));
    end
  end

  // Counter/overflow next state: upd > RC clear > increment, then strobed bus lanes on top.
  always_comb begin
    w_cnt_nxt = r_cnt;
    w_ovf_nxt = r_ovf;
    w_ovf_evt = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (cnt_upd[i]) begin
        w_cnt_nxt[i] = cnt_new[i*CNT_W +: CNT_W];
      end else if (w_rd_ch[i] && (RC != 0)) begin
        w_cnt_nxt[i] = CNT_W'(w_inc_eff[i]);
        w_ovf_nxt[i] = 1'b0;
      end else if (w_inc_eff[i]) begin
        if (r_cnt[i] == CNT_MAX) begin
          w_ovf_evt[i] = 1'b1;
          w_cnt_nxt[i] = (SAT != 0) ? CNT_MAX : {CNT_W{1'b0}};
        end else begin
          w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
        end
      end else begin
        w_cnt_nxt[i] = r_cnt[i];
      end
      if (w_wr_ch[i]) begin
        w_cnt_nxt[i] = (w_cnt_nxt[i] & ~w_bit_en[CNT_W-1:0])
                     | (lb.lb_wdata[CNT_W-1:0] & w_bit_en[CNT_W-1:0]);
      end else begin
        w_cnt_nxt[i] = w_cnt_nxt[i];
      end
      // W1C is applied before the overflow event so a simultaneous set wins.
      if (w_wr_ch[i] && w_bit_en[DATA_W-1] && lb.lb_wdata[DATA_W-1]) begin
        w_ovf_nxt[i] = 1'b0;
      end else begin
        w_ovf_nxt[i] = w_ovf_nxt[i];
      end
      if (w_ovf_evt[i]) begin
        w_ovf_nxt[i] = 1'b1;
      end else begin
        w_ovf_nxt[i] = w_ovf_nxt[i];
      end
    end
  end

  // CTRL next state with byte-lane masking.
  always_comb begin
    if (w_wr_ctrl) begin
      w_inc_en_nxt = (r_inc_en & ~w_bit_en[N_CH-1:0]) | (lb.lb_wdata[N_CH-1:0] & w_bit_en[N_CH-1:0]);
      w_irq_en_nxt = (r_irq_en & ~w_bit_en[16+N_CH-1:16])
                   | (lb.lb_wdata[16+N_CH-1:16] & w_bit_en[16+N_CH-1:16]);
    end else begin
      w_inc_en_nxt = r_inc_en;
      w_irq_en_nxt = r_irq_en;
    end
  end

  // Read data mux; unmapped addresses return zero.
  always_comb begin
    w_rdata = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (w_rd_ch[i]) begin
        w_rdata[CNT_W-1:0] = r_cnt[i];
        w_rdata[DATA_W-1]  = r_ovf[i];
      end else begin
        w_rdata = w_rdata;
      end
    end
    if (w_rd_ctrl) begin
      w_rdata[N_CH-1:0]       = r_inc_en;
      w_rdata[16+N_CH-1:16]   = r_irq_en;
    end else begin
      w_rdata = w_rdata;
    end
  end

  // State registers, handshakes and interrupt.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt    <= '0;
      r_ovf    <= '0;
      r_inc_en <= '1;
      r_irq_en <= '0;
      r_wready <= 1'b0;
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_irq    <= 1'b0;
    end else begin
      r_cnt    <= w_cnt_nxt;
      r_ovf    <= w_ovf_nxt;
      r_inc_en <= w_inc_en_nxt;
      r_irq_en <= w_irq_en_nxt;
      r_wready <= lb.lb_wen;
      r_rvalid <= lb.lb_ren;
      r_rdata  <= lb.lb_ren ? w_rdata : r_rdata;
      r_irq    <= |(r_ovf & r_irq_en);
    end
  end

  assign lb.lb_wready = r_wready;
  assign lb.lb_rvalid = r_rvalid;
  assign lb.lb_rdata  = r_rdata;
  assign cnt_val      = r_cnt;
  assign cnt_ovf      = r_ovf;
  assign irq          = r_irq;

endmodule
